// File: rtl/qerv_ibus_prefetch_pkg.sv
// Shared definitions for the ibus prefetcher: FSM states, word step, address helper.
package qerv_ibus_prefetch_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_PREF  = 2'd2,
      S_STALL = 2'd3
   } pf_state_e;

   localparam logic [31:0] WORD_INC = 32'd4;

   // Word-aligned successor address, wraps mod 2^32.
   function automatic logic [31:0] next_word(input logic [31:0] adr);
      return {adr[31:2], 2'b00} + WORD_INC;
   endfunction

endpackage

// File: rtl/qerv_ibus_pf_buf.sv
// Single-entry prefetch buffer: tag/data/valid with hit compare.
// Flush clears valid and masks a same-cycle hit; flush beats fill.
module qerv_ibus_pf_buf #(
   parameter string RESET_STRATEGY = "MINI"
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        fill_i,
   input  logic [29:0] fill_tag_i,
   input  logic [31:0] fill_data_i,
   input  logic        flush_i,
   input  logic [29:0] lookup_tag_i,
   output logic        hit_o,
   output logic [31:0] data_o
);
   import qerv_ibus_prefetch_pkg::*;

   localparam bit RST_EN = (RESET_STRATEGY != "NONE");

   logic        valid_q, valid_d;
   logic [29:0] tag_q;
   logic [31:0] data_q;

   // Valid next-state: flush has priority over fill.
   always_comb begin
      valid_d = valid_q;
      if (flush_i)
         valid_d = 1'b0;
      else if (fill_i)
         valid_d = 1'b1;
   end

   // Valid register, the only resettable state here.
   always_ff @(posedge clk_i) begin
      if (RST_EN && rst_i)
         valid_q <= 1'b0;
      else
         valid_q <= valid_d;
   end

   // Tag/data storage, loaded on fill only.
   always_ff @(posedge clk_i) begin
      if (fill_i) begin
         tag_q  <= fill_tag_i;
         data_q <= fill_data_i;
      end
   end

   assign hit_o  = valid_q && (tag_q == lookup_tag_i) && !flush_i;
   assign data_o = data_q;

endmodule

// File: rtl/qerv_ibus_prefetch.sv
// Sequential instruction prefetcher between core ibus and instruction memory.
// Optional QERV_IBUS_PF_STATS_EN adds o_hit_cnt/o_miss_cnt counters.
module qerv_ibus_prefetch #(
   parameter string RESET_STRATEGY = "MINI",
   parameter int    PREFETCH       = 1
) (
   input  logic        clk,
   input  logic        i_rst,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   input  logic        i_flush,
   output logic [31:0] o_mem_adr,
   output logic        o_mem_cyc,
   input  logic [31:0] i_mem_rdt,
   input  logic        i_mem_ack
`ifdef QERV_IBUS_PF_STATS_EN
   ,
   output logic [31:0] o_hit_cnt,
   output logic [31:0] o_miss_cnt
`endif
);
   import qerv_ibus_prefetch_pkg::*;

   localparam bit RST_EN = (RESET_STRATEGY != "NONE");
   localparam bit PF_EN  = (PREFETCH != 0);

   pf_state_e   state_q, state_d;
   logic        mem_cyc_q, mem_cyc_d;
   logic [31:0] mem_adr_q, mem_adr_d;
   logic        ack_q, ack_d;
   logic [31:0] rdt_q, rdt_d;

   logic        buf_fill;
   logic        buf_hit;
   logic [31:0] buf_data;
   logic        cnt_hit, cnt_miss;

   logic        cyc_eff;
   logic        adr_match;
   logic [31:0] core_word;

   logic        unused_adr_lsb;
   assign unused_adr_lsb = ^i_ibus_adr[1:0];

   // Core keeps cyc high during our ack cycle; that request is already served.
   assign cyc_eff   = i_ibus_cyc && !ack_q;
   assign adr_match = (i_ibus_adr[31:2] == mem_adr_q[31:2]);
   assign core_word = {i_ibus_adr[31:2], 2'b00};

   qerv_ibus_pf_buf #(
      .RESET_STRATEGY (RESET_STRATEGY)
   ) u_buf (
      .clk_i        (clk),
      .rst_i        (i_rst),
      .fill_i       (buf_fill),
      .fill_tag_i   (mem_adr_q[31:2]),
      .fill_data_i  (i_mem_rdt),
      .flush_i      (i_flush),
      .lookup_tag_i (i_ibus_adr[31:2]),
      .hit_o        (buf_hit),
      .data_o       (buf_data)
   );

   // Next-state and output logic for the fetch/prefetch FSM.
   always_comb begin
      state_d   = state_q;
      mem_cyc_d = mem_cyc_q;
      mem_adr_d = mem_adr_q;
      ack_d     = 1'b0;
      rdt_d     = rdt_q;
      buf_fill  = 1'b0;
      cnt_hit   = 1'b0;
      cnt_miss  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (cyc_eff) begin
               mem_cyc_d = 1'b1;
               if (PF_EN && buf_hit) begin
                  ack_d     = 1'b1;
                  rdt_d     = buf_data;
                  mem_adr_d = next_word(core_word);
                  state_d   = S_PREF;
                  cnt_hit   = 1'b1;
               end else begin
                  mem_adr_d = core_word;
                  state_d   = S_FETCH;
                  cnt_miss  = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if (i_mem_ack) begin
               ack_d = 1'b1;
               rdt_d = i_mem_rdt;
               if (PF_EN) begin
                  mem_adr_d = next_word(mem_adr_q);
                  state_d   = S_PREF;
               end else begin
                  mem_cyc_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
         end
         S_PREF: begin
            if (i_mem_ack) begin
               if (!i_flush && cyc_eff && adr_match) begin
                  buf_fill  = 1'b1;
                  ack_d     = 1'b1;
                  rdt_d     = i_mem_rdt;
                  mem_adr_d = next_word(mem_adr_q);
                  cnt_hit   = 1'b1;
               end else if (cyc_eff) begin
                  buf_fill  = !i_flush;
                  mem_adr_d = core_word;
                  state_d   = S_FETCH;
                  cnt_miss  = 1'b1;
               end else begin
                  buf_fill  = !i_flush;
                  mem_cyc_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end else if (i_flush || (cyc_eff && !adr_match)) begin
               // Wishbone cycle cannot be aborted: drain and discard.
               state_d = S_STALL;
            end
         end
         S_STALL: begin
            if (i_mem_ack) begin
               if (cyc_eff) begin
                  mem_adr_d = core_word;
                  state_d   = S_FETCH;
                  cnt_miss  = 1'b1;
               end else begin
                  mem_cyc_d = 1'b0;
                  state_d   = S_IDLE;
               end
            end
         end
         default: begin
            mem_cyc_d = 1'b0;
            state_d   = S_IDLE;
         end
      endcase
   end

   // Control registers with reset.
   always_ff @(posedge clk) begin
      if (RST_EN && i_rst) begin
         state_q   <= S_IDLE;
         mem_cyc_q <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         mem_cyc_q <= mem_cyc_d;
         ack_q     <= ack_d;
      end
   end

   // Datapath registers, never reset.
   always_ff @(posedge clk) begin
      mem_adr_q <= mem_adr_d;
      rdt_q     <= rdt_d;
   end

   assign o_mem_adr  = mem_adr_q;
   assign o_mem_cyc  = mem_cyc_q;
   assign o_ibus_ack = ack_q;
   assign o_ibus_rdt = rdt_q;

`ifdef QERV_IBUS_PF_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   // Hit/miss event counters, wrap at 2^32.
   always_ff @(posedge clk) begin
      if (RST_EN && i_rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (cnt_hit)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (cnt_miss)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign o_hit_cnt  = hit_cnt_q;
   assign o_miss_cnt = miss_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = cnt_hit ^ cnt_miss;
`endif

endmodule

// File: tb/tb_qerv_ibus_prefetch.sv
// Directed bench for qerv_ibus_prefetch with a fixed-latency Wishbone memory.
module tb_qerv_ibus_prefetch;

   logic        clk = 1'b0;
   logic        i_rst;
   logic [31:0] i_ibus_adr;
   logic        i_ibus_cyc;
   logic [31:0] o_ibus_rdt;
   logic        o_ibus_ack;
   logic        i_flush;
   logic [31:0] o_mem_adr;
   logic        o_mem_cyc;
   logic [31:0] i_mem_rdt = 32'h0;
   logic        i_mem_ack = 1'b0;
`ifdef QERV_IBUS_PF_STATS_EN
   logic [31:0] o_hit_cnt;
   logic [31:0] o_miss_cnt;
`endif

   int          n_cmp = 0;
   int          n_err = 0;
   int          mem_lat = 2;
   int          slv_cnt = 0;
   logic [31:0] ack_log[$];

   always #5 clk = ~clk;

   qerv_ibus_prefetch #(
      .RESET_STRATEGY ("MINI"),
      .PREFETCH       (1)
   ) dut (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_ibus_adr (i_ibus_adr),
      .i_ibus_cyc (i_ibus_cyc),
      .o_ibus_rdt (o_ibus_rdt),
      .o_ibus_ack (o_ibus_ack),
      .i_flush    (i_flush),
      .o_mem_adr  (o_mem_adr),
      .o_mem_cyc  (o_mem_cyc),
      .i_mem_rdt  (i_mem_rdt),
      .i_mem_ack  (i_mem_ack)
`ifdef QERV_IBUS_PF_STATS_EN
      ,
      .o_hit_cnt  (o_hit_cnt),
      .o_miss_cnt (o_miss_cnt)
`endif
   );

   // Memory slave: acks mem_lat cycles after a request starts; data = {AAAA, adr[15:0]}.
   always begin
      @(posedge clk);
      #1;
      if (i_rst) begin
         i_mem_ack = 1'b0;
         slv_cnt   = 0;
      end else if (i_mem_ack) begin
         i_mem_ack = 1'b0;
         slv_cnt   = o_mem_cyc ? 1 : 0;
      end else if (o_mem_cyc) begin
         slv_cnt++;
         if (slv_cnt >= mem_lat) begin
            i_mem_ack = 1'b1;
            i_mem_rdt = {16'hAAAA, o_mem_adr[15:0]};
            ack_log.push_back(o_mem_adr);
         end
      end else begin
         slv_cnt = 0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Core fetch: raise cyc, wait for ack (bounded), check latency/data, drop cyc after ack cycle.
   task automatic fetch(input string tag, input logic [31:0] adr, input logic with_flush,
                        input int exp_lat, input logic [31:0] exp_data);
      int n;
      n          = 0;
      i_ibus_adr = adr;
      i_ibus_cyc = 1'b1;
      i_flush    = with_flush;
      while (n < 40) begin
         @(posedge clk);
         #1;
         i_flush = 1'b0;
         n++;
         if (o_ibus_ack) break;
      end
      check_eq({tag, " latency"}, n, exp_lat);
      check_eq({tag, " rdt"}, o_ibus_rdt, exp_data);
      @(posedge clk);
      #1;
      i_ibus_cyc = 1'b0;
      check_eq({tag, " single ack"}, {31'd0, o_ibus_ack}, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int acks;
      i_rst      = 1'b1;
      i_ibus_adr = 32'h0;
      i_ibus_cyc = 1'b0;
      i_flush    = 1'b0;
      idle(3);
      check_eq("reset ack", {31'd0, o_ibus_ack}, 32'd0);
      check_eq("reset mem_cyc", {31'd0, o_mem_cyc}, 32'd0);
      i_rst = 1'b0;
      idle(2);

      // 1: miss then sequential hit
      fetch("t1 miss", 32'h0000_0100, 1'b0, 3, 32'hAAAA_0100);
      check_eq("t1 pref adr", o_mem_adr, 32'h0000_0104);
      check_eq("t1 pref cyc", {31'd0, o_mem_cyc}, 32'd1);
      idle(3);
      fetch("t1 hit", 32'h0000_0104, 1'b0, 1, 32'hAAAA_0104);
      check_eq("t1 chain adr", o_mem_adr, 32'h0000_0108);
      idle(4);
      mem_lat = 4;

      // 3: core request matches in-flight prefetch
      fetch("t3 miss", 32'h0000_0300, 1'b0, 5, 32'hAAAA_0300);
      fetch("t3 match", 32'h0000_0304, 1'b0, 3, 32'hAAAA_0304);
      check_eq("t3 chain adr", o_mem_adr, 32'h0000_0308);

      // 2: jump while prefetch in flight
      fetch("t2 jump", 32'h0000_0400, 1'b0, 7, 32'hAAAA_0400);
      check_eq("t2 drained pref", ack_log[ack_log.size()-2], 32'h0000_0308);
      check_eq("t2 fetch adr", ack_log[ack_log.size()-1], 32'h0000_0400);
      check_eq("t2 pref adr", o_mem_adr, 32'h0000_0404);
      idle(8);

      // 4: flush
      i_flush = 1'b1;
      idle(1);
      i_flush = 1'b0;
      fetch("t4 after flush", 32'h0000_0404, 1'b0, 5, 32'hAAAA_0404);
      i_flush = 1'b1;
      idle(1);
      i_flush = 1'b0;
      idle(6);
      check_eq("t4 drained", {31'd0, o_mem_cyc}, 32'd0);
      fetch("t4 pref flushed", 32'h0000_0408, 1'b0, 5, 32'hAAAA_0408);
      idle(8);
      fetch("t4 flush+hit", 32'h0000_040C, 1'b1, 5, 32'hAAAA_040C);
      idle(8);

      // 5: address wrap
      fetch("t5 top", 32'hFFFF_FFFC, 1'b0, 5, 32'hAAAA_FFFC);
      check_eq("t5 wrap adr", o_mem_adr, 32'h0000_0000);
      idle(8);
      fetch("t5 wrap hit", 32'h0000_0000, 1'b0, 1, 32'hAAAA_0000);
      check_eq("t5 next adr", o_mem_adr, 32'h0000_0004);
      idle(8);

`ifdef QERV_IBUS_PF_STATS_EN
      check_eq("stats hits", o_hit_cnt, 32'd3);
      check_eq("stats misses", o_miss_cnt, 32'd7);
`endif

      // 6: reset mid-fetch
      i_ibus_adr = 32'h0000_0500;
      i_ibus_cyc = 1'b1;
      idle(2);
      check_eq("t6 fetch cyc", {31'd0, o_mem_cyc}, 32'd1);
      i_rst = 1'b1;
      idle(1);
      check_eq("t6 rst mem_cyc", {31'd0, o_mem_cyc}, 32'd0);
      check_eq("t6 rst ack", {31'd0, o_ibus_ack}, 32'd0);
`ifdef QERV_IBUS_PF_STATS_EN
      check_eq("t6 rst hits", o_hit_cnt, 32'd0);
      check_eq("t6 rst misses", o_miss_cnt, 32'd0);
`endif
      i_rst      = 1'b0;
      i_ibus_cyc = 1'b0;
      acks       = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (o_ibus_ack) acks++;
      end
      check_eq("t6 dropped ack", acks, 0);
      check_eq("t6 idle mem_cyc", {31'd0, o_mem_cyc}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
